// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline stage: NCH channels of WIDTH bits, valid/ready with a 2-entry skid buffer,
// registered in_ready, flush to per-channel bubble values and a saturating back-pressure counter.
module pipeline_stage_elastic #(
   parameter int                   WIDTH       = 32,
   parameter int                   NCH         = 3,
   parameter logic [NCH*WIDTH-1:0] BUBBLE_VAL  = '0,
   parameter int                   STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCH*WIDTH-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NCH*WIDTH-1:0]   out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   // Handshake contract: a transfer happens on a rising edge where valid && ready are both high;
   // valid never depends on ready, and in_ready comes straight from a flop.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

   state_t               state_q, state_d;
   logic [NCH*WIDTH-1:0] main_q, main_d;
   logic [NCH*WIDTH-1:0] skid_q, skid_d;
   logic                 acc, pop;

   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE_VAL;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (acc && !pop) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (acc && pop) begin
                  main_d  = in_data;
               end else if (pop) begin
                  // Leaving by pop restores the bubble so out_data is clean while idle.
                  state_d = EMPTY;
                  main_d  = BUBBLE_VAL;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= EMPTY;
         main_q   <= BUBBLE_VAL;
         skid_q   <= BUBBLE_VAL;
         in_ready <= 1'b1;
      end else begin
         state_q  <= state_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
         in_ready <= (state_d != FULL);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Directed bench for pipeline_stage_elastic: a driver with an occupancy model pushes accepted items
// into exp_q, and an independent monitor pops and compares on every output transfer.
module tb_pipeline_stage_elastic;

   localparam int              WIDTH = 32;
   localparam int              NCH   = 3;
   localparam int              DW    = NCH * WIDTH;
   localparam int              SCW   = 4;
   localparam logic [DW-1:0]   BUB   = {32'h1, 32'h0, 32'h0};
   localparam logic [SCW-1:0]  SMAX  = '1;

   logic           clk;
   logic           resetn;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic [1:0]     occupancy;
   logic [SCW-1:0] stall_cnt;

   logic [DW-1:0]  exp_q[$];
   int             exp_occ;
   logic [SCW-1:0] exp_stall;
   int             checks;
   int             errors;

   pipeline_stage_elastic #(
      .WIDTH(WIDTH), .NCH(NCH), .BUBBLE_VAL(BUB), .STALL_CNT_W(SCW)
   ) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   // Compares the visible state against the model, then advances the model as the next edge will.
   task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
      logic m_acc, m_pop;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      chk("in_ready",  {95'd0, in_ready},  {95'd0, exp_occ != 2});
      chk("out_valid", {95'd0, out_valid}, {95'd0, exp_occ != 0});
      chk("occupancy", {94'd0, occupancy}, DW'(exp_occ));
      chk("stall_cnt", {92'd0, stall_cnt}, {92'd0, exp_stall});
      if (exp_occ == 0) chk("idle_bubble", out_data, BUB);
      m_acc = iv && (exp_occ != 2) && !fl;
      m_pop = (exp_occ != 0) && ordy && !fl;
      if ((exp_occ != 0) && !ordy && !fl && (exp_stall != SMAX)) exp_stall++;
      if (fl) begin
         exp_occ = 0;
         exp_q.delete();
      end else begin
         exp_occ = exp_occ + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
         if (m_acc) exp_q.push_back(id);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_occ   = 0;
      exp_stall = '0;
   endtask

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_item actual=%h required=none", out_data);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();

      // 1. reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
      chk("rst_in_ready",  {95'd0, in_ready},  96'd1);
      chk("rst_out_data",  out_data, {32'h1, 64'h0});
      chk("rst_stall_cnt", {92'd0, stall_cnt}, 96'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // 2. stream 0x10..0x1F at full rate
      for (int i = 16; i < 32; i++) begin
         step(1'b1, {32'(i), 32'(i + 100), 32'(i + 200)}, 1'b1, 1'b0);
         if (i > 16) chk("stream_occ1", {94'd0, occupancy}, 96'd1);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // 3. back-pressure fills both entries, then drain in order
      step(1'b1, {32'hA, 32'hA1, 32'hA2}, 1'b0, 1'b0);
      step(1'b1, {32'hB, 32'hB1, 32'hB2}, 1'b0, 1'b0);
      step(1'b1, {32'hC, 32'hC1, 32'hC2}, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // 4. flush while FULL with an item on offer
      step(1'b1, {32'hD, 32'hD1, 32'hD2}, 1'b0, 1'b0);
      step(1'b1, {32'hE, 32'hE1, 32'hE2}, 1'b0, 1'b0);
      step(1'b1, {32'hF, 32'hF1, 32'hF2}, 1'b1, 1'b1);
      chk("flush_out_data", out_data, BUB);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, {32'h77, 32'h0, 32'h0}, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // 5. hold one item under back-pressure long enough to saturate the counter
      step(1'b1, {32'h55, 32'h56, 32'h57}, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
      chk("stall_saturated", {92'd0, stall_cnt}, 96'd15);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // 6. asynchronous reset between edges while items are in flight
      step(1'b1, {32'h61, 32'h0, 32'h0}, 1'b0, 1'b0);
      step(1'b1, {32'h62, 32'h0, 32'h0}, 1'b0, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_out_valid", {95'd0, out_valid}, 96'd0);
      chk("arst_in_ready",  {95'd0, in_ready},  96'd1);
      chk("arst_occupancy", {94'd0, occupancy}, 96'd0);
      chk("arst_stall_cnt", {92'd0, stall_cnt}, 96'd0);
      chk("arst_out_data",  out_data, BUB);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, {32'h99, 32'h98, 32'h97}, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
